// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the 16-bit pipeline.
// Combines load-use hazards, MEM-resolved taken branches and the multi-cycle
// EX unit handshake into PC / IF/ID / ID/EX / EX/MEM stall and flush controls.
// Optional build macro HAZ_PERF_CNT_EN adds a saturating stall-cycle counter;
// without it stall_cycles is tied to zero.
// When stall and flush both target one register, the pipe registers apply the flush.

module pipe_hazard_ctrl #(
   parameter int REG_AW       = 4,
   parameter int REDIRECT_CYC = 1,
   parameter int MC_TIMEOUT   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_mc_start,
   input  logic              ex_mc_done,
   input  logic              mem_branch,
   input  logic              mem_branch_ne,
   input  logic              mem_zero,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              stall_id_ex,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              flush_mem,
   output logic              pc_sel_branch,
   output logic              mc_abort,
   output logic              mc_timeout,
   output logic [15:0]       stall_cycles
);

   localparam int MC_CW = $clog2(MC_TIMEOUT + 1);
   localparam logic [MC_CW-1:0] MC_LIMIT      = MC_CW'(MC_TIMEOUT);
   localparam logic [MC_CW-1:0] MC_FIRST      = MC_CW'(1);
   localparam logic [1:0]       REDIRECT_LOAD = 2'(REDIRECT_CYC);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MC_WAIT  = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [MC_CW-1:0] mc_cnt;
   logic [MC_CW-1:0] mc_cnt_next;
   logic [1:0]       redir_cnt;
   logic [1:0]       redir_cnt_next;
   logic             timeout_q;
   logic             timeout_set;
   logic             br_taken;
   logic             load_use;
   logic             rs1_hit;
   logic             rs2_hit;

   // Branch resolution and load-use detection; a MEM slot claiming both BEQ and BNE is not taken, R0 never hazards.
   always_comb begin
      br_taken = ((mem_branch & mem_zero) | (mem_branch_ne & ~mem_zero))
                 & ~(mem_branch & mem_branch_ne);
      rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
      rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
      load_use = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);
   end

   // Next-state and control decode; everything is held at zero while reset is asserted.
   always_comb begin
      stall_pc       = 1'b0;
      stall_if_id    = 1'b0;
      stall_id_ex    = 1'b0;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      flush_mem      = 1'b0;
      pc_sel_branch  = 1'b0;
      mc_abort       = 1'b0;
      state_next     = state;
      mc_cnt_next    = mc_cnt;
      redir_cnt_next = redir_cnt;
      timeout_set    = 1'b0;
      if (!rst) begin
         unique case (state)
            RUN: begin
               if (br_taken) begin
                  pc_sel_branch  = 1'b1;
                  flush_if_id    = 1'b1;
                  flush_id_ex    = 1'b1;
                  flush_mem      = 1'b1;
                  state_next     = REDIRECT;
                  redir_cnt_next = REDIRECT_LOAD;
               end else if (ex_mc_start && !ex_mc_done) begin
                  stall_pc    = 1'b1;
                  stall_if_id = 1'b1;
                  stall_id_ex = 1'b1;
                  flush_mem   = 1'b1;
                  state_next  = MC_WAIT;
                  mc_cnt_next = MC_FIRST;
               end else if (!ex_mc_start && load_use) begin
                  stall_pc    = 1'b1;
                  stall_if_id = 1'b1;
                  flush_id_ex = 1'b1;
               end
            end
            MC_WAIT: begin
               if (br_taken) begin
                  pc_sel_branch  = 1'b1;
                  flush_if_id    = 1'b1;
                  flush_id_ex    = 1'b1;
                  flush_mem      = 1'b1;
                  mc_abort       = 1'b1;
                  state_next     = REDIRECT;
                  redir_cnt_next = REDIRECT_LOAD;
               end else if (ex_mc_done) begin
                  state_next = RUN;
               end else if (mc_cnt == MC_LIMIT) begin
                  stall_pc    = 1'b1;
                  stall_if_id = 1'b1;
                  stall_id_ex = 1'b1;
                  flush_mem   = 1'b1;
                  mc_abort    = 1'b1;
                  timeout_set = 1'b1;
                  state_next  = RUN;
               end else begin
                  stall_pc    = 1'b1;
                  stall_if_id = 1'b1;
                  stall_id_ex = 1'b1;
                  flush_mem   = 1'b1;
                  mc_cnt_next = mc_cnt + 1'b1;
               end
            end
            REDIRECT: begin
               flush_if_id = 1'b1;
               if (redir_cnt == 2'd1) begin
                  state_next = RUN;
               end else begin
                  redir_cnt_next = redir_cnt - 2'd1;
               end
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   // State, sequencing counters and the sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         mc_cnt    <= '0;
         redir_cnt <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         mc_cnt    <= mc_cnt_next;
         redir_cnt <= redir_cnt_next;
         timeout_q <= timeout_q | timeout_set;
      end
   end

   assign mc_timeout = timeout_q & ~rst;

`ifdef HAZ_PERF_CNT_EN
   logic [15:0] stall_cnt;

   // Count every cycle the PC is held, saturating at the top value.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_pc && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign stall_cycles = rst ? 16'd0 : stall_cnt;
`else
   assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by random traffic,
// each cycle compared against a behavioural model of the hazard rules.

module tb_pipe_hazard_ctrl;

   localparam int REG_AW       = 4;
   localparam int REDIRECT_CYC = 2;
   localparam int MC_TIMEOUT   = 6;

   // Control vector order: {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_mem, pc_sel_branch, mc_abort}
   localparam logic [7:0] BRANCH_SET = 8'b0001_1110;
   localparam logic [7:0] STALL_SET  = 8'b1110_0100;
   localparam logic [7:0] LU_SET     = 8'b1100_1000;
   localparam logic [7:0] REDIR_SET  = 8'b0001_0000;
   localparam logic [7:0] ABORT_BIT  = 8'b0000_0001;

   typedef struct packed {
      logic              rst;
      logic [REG_AW-1:0] id_rs1;
      logic [REG_AW-1:0] id_rs2;
      logic              id_uses_rs1;
      logic              id_uses_rs2;
      logic [REG_AW-1:0] ex_rd;
      logic              ex_mem_read;
      logic              ex_mc_start;
      logic              ex_mc_done;
      logic              mem_branch;
      logic              mem_branch_ne;
      logic              mem_zero;
   } stim_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [REG_AW-1:0] id_rs1 = '0;
   logic [REG_AW-1:0] id_rs2 = '0;
   logic              id_uses_rs1 = 1'b0;
   logic              id_uses_rs2 = 1'b0;
   logic [REG_AW-1:0] ex_rd = '0;
   logic              ex_mem_read = 1'b0;
   logic              ex_mc_start = 1'b0;
   logic              ex_mc_done = 1'b0;
   logic              mem_branch = 1'b0;
   logic              mem_branch_ne = 1'b0;
   logic              mem_zero = 1'b0;
   logic              stall_pc;
   logic              stall_if_id;
   logic              stall_id_ex;
   logic              flush_if_id;
   logic              flush_id_ex;
   logic              flush_mem;
   logic              pc_sel_branch;
   logic              mc_abort;
   logic              mc_timeout;
   logic [15:0]       stall_cycles;

   int checks   = 0;
   int failures = 0;

   bit m_waiting    = 1'b0;
   int m_wait_count = 0;
   int m_flush_left = 0;
   bit m_timeout    = 1'b0;
   int m_perf       = 0;

   pipe_hazard_ctrl #(
      .REG_AW       (REG_AW),
      .REDIRECT_CYC (REDIRECT_CYC),
      .MC_TIMEOUT   (MC_TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_uses_rs1   (id_uses_rs1),
      .id_uses_rs2   (id_uses_rs2),
      .ex_rd         (ex_rd),
      .ex_mem_read   (ex_mem_read),
      .ex_mc_start   (ex_mc_start),
      .ex_mc_done    (ex_mc_done),
      .mem_branch    (mem_branch),
      .mem_branch_ne (mem_branch_ne),
      .mem_zero      (mem_zero),
      .stall_pc      (stall_pc),
      .stall_if_id   (stall_if_id),
      .stall_id_ex   (stall_id_ex),
      .flush_if_id   (flush_if_id),
      .flush_id_ex   (flush_id_ex),
      .flush_mem     (flush_mem),
      .pc_sel_branch (pc_sel_branch),
      .mc_abort      (mc_abort),
      .mc_timeout    (mc_timeout),
      .stall_cycles  (stall_cycles)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the falling edge.
   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      rst           = s.rst;
      id_rs1        = s.id_rs1;
      id_rs2        = s.id_rs2;
      id_uses_rs1   = s.id_uses_rs1;
      id_uses_rs2   = s.id_uses_rs2;
      ex_rd         = s.ex_rd;
      ex_mem_read   = s.ex_mem_read;
      ex_mc_start   = s.ex_mc_start;
      ex_mc_done    = s.ex_mc_done;
      mem_branch    = s.mem_branch;
      mem_branch_ne = s.mem_branch_ne;
      mem_zero      = s.mem_zero;
   endtask

   // Predict this cycle from the hazard rules, compare, then advance the model.
   task automatic checkOutput(input string tag);
      logic [7:0]  exp_ctl;
      logic [7:0]  obs_ctl;
      logic        exp_to;
      logic [15:0] exp_perf;
      logic [REG_AW-1:0] srcs [2];
      bit          uses [2];
      bit          taken;
      bit          hazard;
      #1;
      taken = (mem_branch && !mem_branch_ne && mem_zero) ||
              (mem_branch_ne && !mem_branch && !mem_zero);
      srcs[0] = id_rs1;  uses[0] = id_uses_rs1;
      srcs[1] = id_rs2;  uses[1] = id_uses_rs2;
      hazard = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (ex_mem_read && ex_rd != 0 && uses[k] && srcs[k] == ex_rd) hazard = 1'b1;
      end

      exp_ctl = '0;
      exp_to  = rst ? 1'b0 : m_timeout;
`ifdef HAZ_PERF_CNT_EN
      exp_perf = rst ? 16'd0 : 16'(m_perf);
`else
      exp_perf = 16'd0;
`endif

      if (rst) begin
         m_waiting    = 1'b0;
         m_wait_count = 0;
         m_flush_left = 0;
         m_timeout    = 1'b0;
      end else if (m_flush_left > 0) begin
         exp_ctl      = REDIR_SET;
         m_flush_left = m_flush_left - 1;
      end else if (m_waiting) begin
         if (taken) begin
            exp_ctl      = BRANCH_SET | ABORT_BIT;
            m_waiting    = 1'b0;
            m_flush_left = REDIRECT_CYC;
         end else if (ex_mc_done) begin
            m_waiting = 1'b0;
         end else if (m_wait_count == MC_TIMEOUT) begin
            exp_ctl   = STALL_SET | ABORT_BIT;
            m_waiting = 1'b0;
            m_timeout = 1'b1;
         end else begin
            exp_ctl      = STALL_SET;
            m_wait_count = m_wait_count + 1;
         end
      end else begin
         if (taken) begin
            exp_ctl      = BRANCH_SET;
            m_flush_left = REDIRECT_CYC;
         end else if (ex_mc_start && !ex_mc_done) begin
            exp_ctl      = STALL_SET;
            m_waiting    = 1'b1;
            m_wait_count = 1;
         end else if (!ex_mc_start && hazard) begin
            exp_ctl = LU_SET;
         end
      end

      if (rst) m_perf = 0;
      else if (exp_ctl[7] && m_perf < 65535) m_perf = m_perf + 1;

      obs_ctl = {stall_pc, stall_if_id, stall_id_ex, flush_if_id,
                 flush_id_ex, flush_mem, pc_sel_branch, mc_abort};

      checks++;
      assert (obs_ctl === exp_ctl) else begin
         failures++;
         $error("[TB] FAIL %s ctl observed=%b expected=%b", tag, obs_ctl, exp_ctl);
      end
      checks++;
      assert (mc_timeout === exp_to) else begin
         failures++;
         $error("[TB] FAIL %s mc_timeout observed=%b expected=%b", tag, mc_timeout, exp_to);
      end
      checks++;
      assert (stall_cycles === exp_perf) else begin
         failures++;
         $error("[TB] FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp_perf);
      end
   endtask

   // Directed scenarios, then randomized traffic, then the summary.
   initial begin
      stim_t s;

      s = '0; s.rst = 1'b1;
      applyStimulus(s); checkOutput("reset0");
      applyStimulus(s); checkOutput("reset1");

      s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 4'd3; s.id_rs2 = 4'd3; s.id_uses_rs2 = 1'b1;
      applyStimulus(s); checkOutput("lu_rs2");
      s = '0;
      applyStimulus(s); checkOutput("lu_release");
      s = '0; s.ex_mem_read = 1'b1; s.id_uses_rs1 = 1'b1; s.id_uses_rs2 = 1'b1;
      applyStimulus(s); checkOutput("lu_r0");
      s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 4'd5; s.id_rs1 = 4'd5;
      applyStimulus(s); checkOutput("lu_unused_src");
      s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 4'd9; s.id_rs1 = 4'd9; s.id_uses_rs1 = 1'b1;
      applyStimulus(s); checkOutput("lu_rs1");

      s = '0; s.mem_branch = 1'b1; s.mem_zero = 1'b1;
      applyStimulus(s); checkOutput("beq_taken");
      s = '0; s.mem_branch = 1'b1; s.mem_zero = 1'b1;
      s.ex_mem_read = 1'b1; s.ex_rd = 4'd2; s.id_rs1 = 4'd2; s.id_uses_rs1 = 1'b1;
      applyStimulus(s); checkOutput("redirect_ignore");
      s = '0;
      applyStimulus(s); checkOutput("redirect_last");
      applyStimulus(s); checkOutput("run_after_redirect");
      s = '0; s.mem_branch_ne = 1'b1; s.mem_zero = 1'b1;
      applyStimulus(s); checkOutput("bne_not_taken");
      s = '0; s.mem_branch = 1'b1; s.mem_branch_ne = 1'b1; s.mem_zero = 1'b1;
      applyStimulus(s); checkOutput("both_branch_flags");

      s = '0; s.ex_mc_start = 1'b1;
      applyStimulus(s); checkOutput("mc_start");
      for (int i = 0; i < 4; i++) begin
         s = '0; s.ex_mc_start = 1'b1;
         applyStimulus(s); checkOutput("mc_wait");
      end
      s = '0; s.ex_mc_done = 1'b1;
      applyStimulus(s); checkOutput("mc_done");
      s = '0;
      applyStimulus(s); checkOutput("mc_after_done");
      s = '0; s.ex_mc_start = 1'b1; s.ex_mc_done = 1'b1;
      s.ex_mem_read = 1'b1; s.ex_rd = 4'd1; s.id_rs1 = 4'd1; s.id_uses_rs1 = 1'b1;
      applyStimulus(s); checkOutput("mc_same_cycle_done");

      s = '0; s.ex_mc_start = 1'b1;
      applyStimulus(s); checkOutput("to_start");
      for (int i = 0; i < MC_TIMEOUT; i++) begin
         s = '0;
         applyStimulus(s); checkOutput("to_wait");
      end
      applyStimulus(s); checkOutput("to_sticky");

      s = '0; s.ex_mc_start = 1'b1;
      applyStimulus(s); checkOutput("br_mc_start");
      s = '0;
      applyStimulus(s); checkOutput("br_mc_wait");
      s = '0; s.ex_mc_done = 1'b1; s.mem_branch_ne = 1'b1;
      applyStimulus(s); checkOutput("br_mc_abort");
      s = '0;
      applyStimulus(s); checkOutput("br_mc_redirect0");
      applyStimulus(s); checkOutput("br_mc_redirect1");

      s = '0; s.ex_mc_start = 1'b1;
      applyStimulus(s); checkOutput("rst_mc_start");
      s = '0;
      applyStimulus(s); checkOutput("rst_mc_wait");
      s = '0; s.rst = 1'b1; s.ex_mc_start = 1'b1; s.mem_branch = 1'b1; s.mem_zero = 1'b1;
      applyStimulus(s); checkOutput("rst_mid_op");
      s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 4'd7; s.id_rs2 = 4'd7; s.id_uses_rs2 = 1'b1;
      applyStimulus(s); checkOutput("rst_back_to_run");

      for (int n = 0; n < 400; n++) begin
         s = '0;
         s.rst           = ($urandom_range(0, 63) == 0);
         s.id_rs1        = REG_AW'($urandom_range(0, 3));
         s.id_rs2        = REG_AW'($urandom_range(0, 3));
         s.id_uses_rs1   = 1'($urandom_range(0, 1));
         s.id_uses_rs2   = 1'($urandom_range(0, 1));
         s.ex_rd         = REG_AW'($urandom_range(0, 3));
         s.ex_mem_read   = 1'($urandom_range(0, 1));
         s.ex_mc_start   = ($urandom_range(0, 5) == 0);
         s.ex_mc_done    = ($urandom_range(0, 4) == 0);
         s.mem_branch    = ($urandom_range(0, 7) == 0);
         s.mem_branch_ne = ($urandom_range(0, 7) == 0);
         s.mem_zero      = 1'($urandom_range(0, 1));
         applyStimulus(s); checkOutput("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
